// File: rtl/aes_pkg.sv
// Shared AES definitions for the AES-256 key schedule: word type, widths,
// forward S-box table and round constants.
package aes_pkg;

    typedef logic [31:0] word_t;

    localparam int KEY_W  = 256;
    localparam int HALF_W = 128;
    localparam int STEPS  = 7;

    // Forward S-box, entry 0 in the most significant byte, one row of 16 per line.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
    endfunction

    // Round constants for the seven AES-256 expansion steps.
    function automatic logic [7:0] rcon(input logic [2:0] idx);
        logic [7:0] rc;
        case (idx)
            3'd0:    rc = 8'h01;
            3'd1:    rc = 8'h02;
            3'd2:    rc = 8'h04;
            3'd3:    rc = 8'h08;
            3'd4:    rc = 8'h10;
            3'd5:    rc = 8'h20;
            3'd6:    rc = 8'h40;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational single-byte AES forward S-box.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = sbox(in_byte);

endmodule

// File: rtl/aes_key_sch.sv
// AES-256 key expansion: one step per clock, each producing the next pair of
// 128-bit round keys; RK14 remains on outData0 once expansion finishes.
module aes_key_sch
    import aes_pkg::*;
(
    input  logic              inClk,
    input  logic              inRst,
    input  logic              inDataWr,
    input  logic [KEY_W-1:0]  inDataData,
    output logic [HALF_W-1:0] outData0,
    output logic [HALF_W-1:0] outData1,
    output logic              outBusy
);

    logic [KEY_W-1:0] st_q, st_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;

    word_t w [8];
    word_t n_lo [4];
    word_t n_hi [4];
    word_t rot_w7, sub_rot, sub_n3;
    logic [KEY_W-1:0] expanded;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w[i] = st_q[KEY_W-1-32*i -: 32];
        end
    end

    assign rot_w7 = {w[7][23:0], w[7][31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox_rot (
            .in_byte  (rot_w7[8*i +: 8]),
            .out_byte (sub_rot[8*i +: 8])
        );
        aes_sbox u_sbox_n3 (
            .in_byte  (n_lo[3][8*i +: 8]),
            .out_byte (sub_n3[8*i +: 8])
        );
    end

    // Lower and upper word chains live in separate processes because the
    // upper chain depends on the S-box of the last lower word.
    always_comb begin
        n_lo[0] = w[0] ^ sub_rot ^ {rcon(cnt_q), 24'h0};
        n_lo[1] = w[1] ^ n_lo[0];
        n_lo[2] = w[2] ^ n_lo[1];
        n_lo[3] = w[3] ^ n_lo[2];
    end

    always_comb begin
        n_hi[0] = w[4] ^ sub_n3;
        n_hi[1] = w[5] ^ n_hi[0];
        n_hi[2] = w[6] ^ n_hi[1];
        n_hi[3] = w[7] ^ n_hi[2];
    end

    assign expanded = {n_lo[0], n_lo[1], n_lo[2], n_lo[3],
                       n_hi[0], n_hi[1], n_hi[2], n_hi[3]};

    // A load restarts the schedule even mid-run; otherwise step while busy.
    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (inDataWr) begin
            st_d   = inDataData;
            cnt_d  = 3'd0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            st_d  = expanded;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'(STEPS - 1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge inClk) begin
        if (inRst) begin
            st_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign outData0 = st_q[KEY_W-1:HALF_W];
    assign outData1 = st_q[HALF_W-1:0];
    assign outBusy  = busy_q;

endmodule

// File: tb/tb_aes_key_sch.sv
// Directed bench for aes_key_sch using the FIPS-197 AES-256 example key.
module tb_aes_key_sch;

    logic         clk;
    logic         rst;
    logic         wr;
    logic [255:0] data;
    logic [127:0] d0;
    logic [127:0] d1;
    logic         busy;

    int errors;
    int checks;

    localparam logic [255:0] KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] RK0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RK1  = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] RK2  = 128'ha573c29fa176c498a97fce93a572c09c;
    localparam logic [127:0] RK3  = 128'h1651a8cd0244beda1a5da4c10640bade;
    localparam logic [127:0] RK14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

    aes_key_sch dut (
        .inClk      (clk),
        .inRst      (rst),
        .inDataWr   (wr),
        .inDataData (data),
        .outData0   (d0),
        .outData1   (d1),
        .outBusy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic load_key(input logic [255:0] k);
        data = k;
        wr   = 1'b1;
        cyc();
        wr   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++;
        if (d0 !== 128'h0) begin errors++; $display("FAIL reset_d0 got=%h want=0", d0); end
        checks++;
        if (d1 !== 128'h0) begin errors++; $display("FAIL reset_d1 got=%h want=0", d1); end
        cyc();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_expand();
        int cycles;
        load_key(KEY);
        data = 256'hdeadbeef_0badf00d_cafebabe_12345678_9abcdef0_55aa55aa_ffffffff_00000000;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL load_busy got=%b want=1", busy); end
        checks++;
        if (d0 !== RK0) begin errors++; $display("FAIL load_rk0 got=%h want=%h", d0, RK0); end
        checks++;
        if (d1 !== RK1) begin errors++; $display("FAIL load_rk1 got=%h want=%h", d1, RK1); end
        cyc();
        checks++;
        if (d0 !== RK2) begin errors++; $display("FAIL step1_rk2 got=%h want=%h", d0, RK2); end
        checks++;
        if (d1 !== RK3) begin errors++; $display("FAIL step1_rk3 got=%h want=%h", d1, RK3); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL step1_busy got=%b want=1", busy); end
        cycles = 1;
        while (busy === 1'b1 && cycles < 20) begin
            cyc();
            cycles++;
        end
        checks++;
        if (cycles != 7) begin errors++; $display("FAIL busy_len got=%0d want=7", cycles); end
        checks++;
        if (d0 !== RK14) begin errors++; $display("FAIL final_rk14 got=%h want=%h", d0, RK14); end
        for (int i = 0; i < 20; i++) begin
            cyc();
            checks++;
            if (d0 !== RK14 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold cycle=%0d got d0=%h busy=%b want d0=%h busy=0", i, d0, busy, RK14);
            end
        end
    endtask

    task automatic test_reload();
        int cycles;
        load_key(KEY);
        cyc();
        wr = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL pre_reload_busy got=%b want=1", busy); end
        load_key(KEY);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL reload_busy got=%b want=1", busy); end
        checks++;
        if (d0 !== RK0) begin errors++; $display("FAIL reload_rk0 got=%h want=%h", d0, RK0); end
        checks++;
        if (d1 !== RK1) begin errors++; $display("FAIL reload_rk1 got=%h want=%h", d1, RK1); end
        cycles = 0;
        while (busy === 1'b1 && cycles < 20) begin
            cyc();
            cycles++;
        end
        checks++;
        if (cycles != 7) begin errors++; $display("FAIL reload_busy_len got=%0d want=7", cycles); end
        checks++;
        if (d0 !== RK14) begin errors++; $display("FAIL reload_rk14 got=%h want=%h", d0, RK14); end
    endtask

    task automatic test_reset_priority();
        load_key(KEY);
        cyc();
        cyc();
        rst  = 1'b1;
        wr   = 1'b1;
        data = KEY;
        cyc();
        rst  = 1'b0;
        wr   = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL prio_busy got=%b want=0", busy); end
        checks++;
        if (d0 !== 128'h0) begin errors++; $display("FAIL prio_d0 got=%h want=0", d0); end
        checks++;
        if (d1 !== 128'h0) begin errors++; $display("FAIL prio_d1 got=%h want=0", d1); end
        cyc();
        checks++;
        if (busy !== 1'b0 || d0 !== 128'h0) begin
            errors++;
            $display("FAIL prio_idle got busy=%b d0=%h want busy=0 d0=0", busy, d0);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        wr     = 1'b0;
        data   = '0;
        cyc();
        test_reset();
        test_expand();
        test_reload();
        test_reset_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
